// File: rtl/cpu_pkg.sv
// Shared encodings for the load/store controller: access sizes, FSM states
// and the request legality check used when a request is accepted.
package cpu_pkg;

    // Access size encodings as presented on the size port
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam logic [1:0] SZ_RSVD = 2'd3;

    // FSM state encodings
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RD   = 2'd1;
    localparam logic [1:0] ST_WR   = 2'd2;
    localparam logic [1:0] ST_RSP  = 2'd3;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RD   = ST_RD,
        WR   = ST_WR,
        RSP  = ST_RSP
    } lsu_state_t;

    // A request is rejected when it is misaligned for its size or uses the
    // reserved size code.
    function automatic logic req_bad(input logic [1:0] sz, input logic [1:0] off);
        logic bad;
        case (sz)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = off[0];
            SZ_WORD: bad = (off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_lane.sv
// Combinational byte-lane helper. With merge=0 it extracts the addressed
// byte/half/word from 'word' and sign- or zero-extends it; with merge=1 it
// returns 'word' with the addressed byte/half replaced from the low bits of
// 'data' (a word-sized merge simply returns 'data').
module lsu_lane
    import cpu_pkg::*;
(
    input  logic        merge,
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        sext,
    input  logic [31:0] data,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] ext;
    logic [31:0] mrg;

    // Lane select, extension and merge; alignment is guaranteed upstream,
    // so the half lane only looks at offset[1].
    always_comb begin
        byte_sel = word[{offset, 3'b000} +: 8];
        half_sel = offset[1] ? word[31:16] : word[15:0];
        ext      = word;
        mrg      = data;
        case (size)
            SZ_BYTE: begin
                ext = {{24{sext & byte_sel[7]}}, byte_sel};
                mrg = word;
                mrg[{offset, 3'b000} +: 8] = data[7:0];
            end
            SZ_HALF: begin
                ext = {{16{sext & half_sel[15]}}, half_sel};
                mrg = word;
                mrg[{offset[1], 4'b0000} +: 16] = data[15:0];
            end
            default: ;
        endcase
        result = merge ? mrg : ext;
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller in front of a word-wide, byte-addressed data memory.
// Loads read one word and extract a lane; sub-word stores read the word,
// merge the new lane and write it back; word stores write directly.
// Illegal requests complete with err and never touch memory.
module lsu_ctrl
    import cpu_pkg::*;
#(
    parameter int          ADDR_W      = 32,
    parameter logic [31:0] RESET_RDATA = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              st,
    input  logic [1:0]        size,
    input  logic              sext,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata_in,
    output logic              ready,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [31:0]       rdata_out,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_rdata,
    output logic              mem_we,
    output logic [31:0]       mem_wdata
);

    lsu_state_t        state, state_nxt;
    logic              st_q;
    logic [1:0]        size_q;
    logic              sext_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              err_q;
    logic [31:0]       merge_q;
    logic [31:0]       lane_ext;
    logic [31:0]       lane_mrg;
    logic              accept;
    logic              bad;

    assign accept = (state == IDLE) && req;
    assign bad    = req_bad(size, addr[1:0]);

    // Extract path: picks the load lane out of the word being read
    lsu_lane u_extract (
        .merge  (1'b0),
        .word   (mem_rdata),
        .offset (addr_q[1:0]),
        .size   (size_q),
        .sext   (sext_q),
        .data   (wdata_q),
        .result (lane_ext)
    );

    // Merge path: folds the store lane into the word being read
    lsu_lane u_merge (
        .merge  (1'b1),
        .word   (mem_rdata),
        .offset (addr_q[1:0]),
        .size   (size_q),
        .sext   (sext_q),
        .data   (wdata_q),
        .result (lane_mrg)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req) begin
                    if (bad)                       state_nxt = RSP;
                    else if (!st || size != SZ_WORD) state_nxt = RD;
                    else                           state_nxt = WR;
                end
            end
            RD:      state_nxt = st_q ? WR : RSP;
            WR:      state_nxt = RSP;
            default: state_nxt = IDLE;
        endcase
    end

    // Request capture at accept time
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st_q    <= 1'b0;
            size_q  <= SZ_BYTE;
            sext_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else if (accept) begin
            st_q    <= st;
            size_q  <= size;
            sext_q  <= sext;
            addr_q  <= addr;
            wdata_q <= wdata_in;
            err_q   <= bad;
        end
    end

    // Write-data register: the full store word on a word store, or the
    // read-merged word during RD of a sub-word store.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            merge_q <= '0;
        end else if (accept && st && size == SZ_WORD) begin
            merge_q <= wdata_in;
        end else if (state == RD && st_q) begin
            merge_q <= lane_mrg;
        end
    end

    // Load result; only a completed load updates it, errors leave it alone
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                     rdata_out <= RESET_RDATA;
        else if (state == RD && !st_q) rdata_out <= lane_ext;
    end

    // Outputs decoded from state so a reset drops mem_we immediately
    always_comb begin
        ready     = (state == IDLE);
        busy      = ~ready;
        done      = (state == RSP);
        err       = done & err_q;
        mem_we    = (state == WR);
        mem_wdata = merge_q;
        mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
    end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store controller directly upstream of the CPU's byte-addressed, word-wide data memory.
- Accepts byte, halfword and word load/store requests from the datapath and checks alignment.
- Performs sub-word stores as read-modify-write, because the memory always writes 4 bytes.
- Returns sign- or zero-extended load data with a registered done pulse; the CPU stalls on busy.

Parameters:
- ADDR_W, 32, width of the byte address passed through to the memory.
- RESET_RDATA, 32'h0000_0000, reset value of rdata_out.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  1  request strobe; sampled only when ready=1.
- st  in  1  1=store, 0=load.
- size  in  2  0=byte, 1=half, 2=word, 3=reserved (error).
- sext  in  1  loads only: 1=sign-extend, 0=zero-extend.
- addr  in  ADDR_W  byte address.
- wdata_in  in  32  store data; right-aligned for sub-word stores.
- ready  out  1  high in IDLE only.
- busy  out  1  equals ~ready; drives the CPU stall.
- done  out  1  one-cycle pulse when an access completes.
- err  out  1  qualified by done; misaligned or reserved-size request.
- rdata_out  out  32  load result; holds until the next load completes.
- mem_addr  out  ADDR_W  word-aligned address {addr_q[ADDR_W-1:2],2'b00}.
- mem_rdata  in  32  combinational read data from the memory.
- mem_we  out  1  memory write enable.
- mem_wdata  out  32  memory write data.

Behaviour:
- Reset (async): state=IDLE; done=0, err=0, rdata_out=RESET_RDATA; request registers cleared. Because mem_we is decoded from state, a reset mid-access kills mem_we immediately and no partial write occurs.
- States: IDLE, RD, WR, RSP.
- IDLE:
  - On req, latch st, size, sext, addr, wdata.
  - Misaligned (size=1 with addr[0]=1; size=2 with addr[1:0]!=0) or size=3: go to RSP with err_q=1. No memory access.
  - Load, or sub-word store: go to RD.
  - Word store: go to WR with merge register = wdata.
- RD: mem_addr valid.
  - Load: extract lane by addr_q[1:0]. Byte lane k = mem_rdata[8k+7:8k]; half lane = addr_q[1]. Extend per sext, write rdata_out, go to RSP.
  - Sub-word store: merge register = mem_rdata with the addressed byte or half replaced from wdata_q low bits. Go to WR.
- WR: mem_we=1, mem_wdata=merge register. Go to RSP.
- RSP: done=1, err=err_q. Return to IDLE. A new req is accepted no earlier than the following cycle.
- Latency from accept cycle to done:
  - error: 1 cycle
  - load: 2 cycles
  - word store: 2 cycles
  - sub-word store: 3 cycles
- req while busy is ignored and not queued; the CPU holds req until ready.
- mem_we=0 in all states except WR. mem_addr holds the latched address outside IDLE.
- On err, rdata_out is unchanged and memory is untouched.
- Address wrap at the top of memory is the memory's concern; the word-aligned mem_addr never straddles a word.

Decomposition:
- Shared package (cpu_pkg) holds:
  - size encodings SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2.
  - state encoding localparams.
- One sub-module, lsu_lane: a combinational lane extract/merge function block with inputs word, offset, size, sext, data. The FSM instantiates it twice: once for extract, once for merge.

Test Plan:
- Memory word @0x10=0x8899AABB; load byte, sext=1, addr 0x13 -> done at +2 cycles, rdata_out=0xFFFFFF88, err=0.
- Same word; load half, sext=0, addr 0x12 -> rdata_out=0x00008899. With sext=1 -> 0xFFFF8899.
- Store byte 0x5A to addr 0x11 -> exactly one mem_we cycle with mem_addr=0x10, mem_wdata=0x88995ABB; done at +3.
- Load word addr 0x06, then store half addr 0x05 -> each gives done+err at +1, mem_we never asserted, rdata_out unchanged.
- Word store 0xDEADBEEF @0x20, with req pulsed again while busy -> single write, second req ignored, ready high only after done.
- Assert reset during RD of a sub-word store -> mem_we stays 0 throughout, word @0x10 unchanged, outputs at reset values, ready=1 after reset release.
